// File: rtl/fir_reload_controller.sv
// Coefficient reload sequencer and sample gate for a banked FIR filter.
// Optional macro FIR_RELOAD_FLUSH_EN adds a flush pass that zeroes the filter delay line.
module fir_reload_controller #(
   parameter int unsigned NTAPS      = 16,
   parameter int unsigned NBANKS     = 4,
   parameter int unsigned RESULT_LAT = 1
) (
   input  logic                                     i_clk,
   input  logic                                     i_reset,
   input  logic                                     i_reload_req,
   input  logic [$clog2(NBANKS)-1:0]                i_bank,
   output logic [$clog2(NBANKS)+$clog2(NTAPS)-1:0] o_coef_addr,
   input  logic [15:0]                              i_coef_data,
   output logic                                     o_tap_wr,
   output logic [15:0]                              o_tap,
   input  logic                                     i_sample_valid,
   output logic                                     o_sample_ready,
   input  logic [15:0]                              i_sample,
   output logic                                     o_ce,
   output logic [15:0]                              o_sample,
   output logic                                     o_result_valid,
   output logic                                     o_busy,
   output logic                                     o_reload_done,
   output logic [$clog2(NBANKS)-1:0]                o_bank_active
);

   localparam int unsigned BW = $clog2(NBANKS);
   localparam int unsigned IW = $clog2(NTAPS);
   localparam logic [IW-1:0] IdxLast = IW'(NTAPS - 1);

`ifdef FIR_RELOAD_FLUSH_EN
   typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;
`else
   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
`endif

   state_e                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BW-1:0]         bank_q, bank_d;
   logic [BW-1:0]         bank_act_q, bank_act_d;
   logic                  tap_wr_q, tap_wr_d;
   logic [15:0]           tap_q, tap_d;
   logic                  ce_q, ce_d;
   logic                  ce_real_q, ce_real_d;
   logic [15:0]           sample_q, sample_d;
   logic                  done_q, done_d;
   logic [RESULT_LAT-1:0] rv_q, rv_d;
   logic                  accept;

   assign o_sample_ready = (state_q == StRun) && !i_reload_req;
   assign accept         = i_sample_valid && o_sample_ready;
   assign o_coef_addr    = {bank_q, idx_q};
   assign o_busy         = (state_q != StIdle) && (state_q != StRun);

   assign o_tap_wr       = tap_wr_q;
   assign o_tap          = tap_q;
   assign o_ce           = ce_q;
   assign o_sample       = sample_q;
   assign o_result_valid = rv_q[RESULT_LAT-1];
   assign o_reload_done  = done_q;
   assign o_bank_active  = bank_act_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      bank_d     = bank_q;
      bank_act_d = bank_act_q;
      tap_wr_d   = 1'b0;
      tap_d      = tap_q;
      ce_d       = 1'b0;
      ce_real_d  = 1'b0;
      sample_d   = sample_q;
      done_d     = 1'b0;

      // A sample accepted on the same cycle RUN is left is still forwarded.
      if (accept) begin
         ce_d      = 1'b1;
         ce_real_d = 1'b1;
         sample_d  = i_sample;
      end

      unique case (state_q)
         StIdle: begin
            if (i_reload_req) begin
               bank_d  = i_bank;
               idx_d   = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            tap_wr_d = 1'b1;
            tap_d    = i_coef_data;
            idx_d    = idx_q + 1'b1;
            if (idx_q == IdxLast) begin
               idx_d = '0;
`ifdef FIR_RELOAD_FLUSH_EN
               state_d = StFlush;
`else
               state_d    = StRun;
               done_d     = 1'b1;
               bank_act_d = bank_q;
`endif
            end
         end
`ifdef FIR_RELOAD_FLUSH_EN
         StFlush: begin
            // Zero samples clock the old history out; they never produce results.
            ce_d     = 1'b1;
            sample_d = '0;
            idx_d    = idx_q + 1'b1;
            if (idx_q == IdxLast) begin
               idx_d      = '0;
               state_d    = StRun;
               done_d     = 1'b1;
               bank_act_d = bank_q;
            end
         end
`endif
         StRun: begin
            if (i_reload_req) begin
               bank_d  = i_bank;
               idx_d   = '0;
               state_d = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase

      rv_d    = rv_q;
      rv_d[0] = ce_real_q;
      for (int unsigned i = 1; i < RESULT_LAT; i++) begin
         rv_d[i] = rv_q[i-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         bank_q     <= '0;
         bank_act_q <= '0;
         tap_wr_q   <= 1'b0;
         tap_q      <= '0;
         ce_q       <= 1'b0;
         ce_real_q  <= 1'b0;
         sample_q   <= '0;
         done_q     <= 1'b0;
         rv_q       <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         bank_q     <= bank_d;
         bank_act_q <= bank_act_d;
         tap_wr_q   <= tap_wr_d;
         tap_q      <= tap_d;
         ce_q       <= ce_d;
         ce_real_q  <= ce_real_d;
         sample_q   <= sample_d;
         done_q     <= done_d;
         rv_q       <= rv_d;
      end
   end

endmodule

// File: tb/tb_fir_reload_controller.sv
// Bench for fir_reload_controller; define FIR_RELOAD_FLUSH_EN for both DUT and bench
// to exercise the flush pass.
module tb_fir_reload_controller;

   localparam int NTAPS      = 16;
   localparam int NBANKS     = 4;
   localparam int RESULT_LAT = 1;
`ifdef FIR_RELOAD_FLUSH_EN
   localparam int FLUSH_CYC = NTAPS;
`else
   localparam int FLUSH_CYC = 0;
`endif
   localparam int INF = 1 << 30;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_reload_req;
   logic [1:0]  i_bank;
   logic [5:0]  o_coef_addr;
   logic [15:0] i_coef_data;
   logic        o_tap_wr;
   logic [15:0] o_tap;
   logic        i_sample_valid;
   logic        o_sample_ready;
   logic [15:0] i_sample;
   logic        o_ce;
   logic [15:0] o_sample;
   logic        o_result_valid;
   logic        o_busy;
   logic        o_reload_done;
   logic [1:0]  o_bank_active;

   logic [15:0] rom_mem [64];
   assign i_coef_data = rom_mem[o_coef_addr];

   fir_reload_controller #(
      .NTAPS      (NTAPS),
      .NBANKS     (NBANKS),
      .RESULT_LAT (RESULT_LAT)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_reload_req   (i_reload_req),
      .i_bank         (i_bank),
      .o_coef_addr    (o_coef_addr),
      .i_coef_data    (i_coef_data),
      .o_tap_wr       (o_tap_wr),
      .o_tap          (o_tap),
      .i_sample_valid (i_sample_valid),
      .o_sample_ready (o_sample_ready),
      .i_sample       (i_sample),
      .o_ce           (o_ce),
      .o_sample       (o_sample),
      .o_result_valid (o_result_valid),
      .o_busy         (o_busy),
      .o_reload_done  (o_reload_done),
      .o_bank_active  (o_bank_active)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          c;
      logic [15:0] v;
   } ev_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic mon_en = 1'b0;

   ev_t act_tap[$], exp_tap[$], act_ce[$], exp_ce[$];
   ev_t act_rv[$], exp_rv[$], act_done[$], exp_done[$];

   // Reference timeline: cycles at which the pending reload starts being busy and enters RUN.
   logic       idle_m;
   int         busy_from, run_from;
   logic [1:0] pend_bank, bank_act_m;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge i_clk) begin
      if (mon_en) begin
         if (o_tap_wr === 1'b1) act_tap.push_back('{c: cyc, v: o_tap});
         if (o_ce === 1'b1) act_ce.push_back('{c: cyc, v: o_sample});
         if (o_result_valid === 1'b1) act_rv.push_back('{c: cyc, v: 16'd0});
         if (o_reload_done === 1'b1) act_done.push_back('{c: cyc, v: 16'd0});
         chk("tap_wr_ce_overlap", 32'(o_tap_wr & o_ce), 32'd0);
      end
   end

   task automatic cmp_ev(input string tag, input ev_t act[$], input ev_t exp[$]);
      chk({tag, "_count"}, 32'(act.size()), 32'(exp.size()));
      for (int i = 0; i < act.size() && i < exp.size(); i++) begin
         chk({tag, "_cycle"}, act[i].c, exp[i].c);
         chk({tag, "_value"}, 32'(act[i].v), 32'(exp[i].v));
      end
   endtask

   task automatic check_logs();
      @(negedge i_clk);
      #1;
      cmp_ev("tap", act_tap, exp_tap);
      cmp_ev("ce", act_ce, exp_ce);
      cmp_ev("result_valid", act_rv, exp_rv);
      cmp_ev("reload_done", act_done, exp_done);
      act_tap.delete(); exp_tap.delete(); act_ce.delete(); exp_ce.delete();
      act_rv.delete(); exp_rv.delete(); act_done.delete(); exp_done.delete();
   endtask

   task automatic check_reset_vals();
      chk("rst_tap_wr", 32'(o_tap_wr), 32'd0);
      chk("rst_tap", 32'(o_tap), 32'd0);
      chk("rst_ce", 32'(o_ce), 32'd0);
      chk("rst_sample", 32'(o_sample), 32'd0);
      chk("rst_result_valid", 32'(o_result_valid), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_reload_done", 32'(o_reload_done), 32'd0);
      chk("rst_bank_active", 32'(o_bank_active), 32'd0);
      chk("rst_ready", 32'(o_sample_ready), 32'd0);
   endtask

   task automatic purge_after(input int r);
      while (exp_tap.size() > 0 && exp_tap[exp_tap.size()-1].c > r) void'(exp_tap.pop_back());
      while (exp_ce.size() > 0 && exp_ce[exp_ce.size()-1].c > r) void'(exp_ce.pop_back());
      while (exp_rv.size() > 0 && exp_rv[exp_rv.size()-1].c > r) void'(exp_rv.pop_back());
      while (exp_done.size() > 0 && exp_done[exp_done.size()-1].c > r) void'(exp_done.pop_back());
   endtask

   // One clock of stimulus plus the checks and predictions that belong to that cycle.
   task automatic cyc_step(input logic v, input logic [15:0] s, input logic req,
                           input logic [1:0] bank, input logic rst);
      logic in_run, exp_rdy, exp_busy;
      @(posedge i_clk);
      #1;
      i_sample_valid = v;
      i_sample       = s;
      i_reload_req   = req;
      i_bank         = bank;
      i_reset        = rst;
      #1;
      in_run = !idle_m && (cyc >= run_from);
      if (in_run) bank_act_m = pend_bank;
      exp_rdy  = in_run && !req;
      exp_busy = !idle_m && (cyc >= busy_from) && (cyc < run_from);
      chk("sample_ready", 32'(o_sample_ready), 32'(exp_rdy));
      chk("busy", 32'(o_busy), 32'(exp_busy));
      chk("bank_active", 32'(o_bank_active), 32'(bank_act_m));
      if (!idle_m && cyc >= busy_from && cyc < busy_from + NTAPS)
         chk("coef_addr", 32'(o_coef_addr), 32'(int'(pend_bank) * NTAPS + (cyc - busy_from)));
      if (!rst) begin
         idle_m     = 1'b1;
         busy_from  = INF;
         run_from   = INF;
         bank_act_m = 2'd0;
         purge_after(cyc);
      end else begin
         if (v && exp_rdy) begin
            exp_ce.push_back('{c: cyc + 1, v: s});
            exp_rv.push_back('{c: cyc + 1 + RESULT_LAT, v: 16'd0});
         end
         if (req && (idle_m || in_run)) begin
            idle_m    = 1'b0;
            pend_bank = bank;
            busy_from = cyc + 1;
            run_from  = cyc + NTAPS + 1 + FLUSH_CYC;
            for (int i = 0; i < NTAPS; i++)
               exp_tap.push_back('{c: cyc + 2 + i, v: rom_mem[int'(bank) * NTAPS + i]});
            for (int i = 0; i < FLUSH_CYC; i++)
               exp_ce.push_back('{c: cyc + NTAPS + 2 + i, v: 16'd0});
            exp_done.push_back('{c: run_from, v: 16'd0});
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      for (int i = 0; i < 64; i++) rom_mem[i] = 16'($urandom);
      idle_m     = 1'b1;
      busy_from  = INF;
      run_from   = INF;
      pend_bank  = 2'd0;
      bank_act_m = 2'd0;

      // Reset held while a request is presented: it must be ignored.
      i_reset        = 1'b0;
      i_reload_req   = 1'b1;
      i_bank         = 2'd2;
      i_sample_valid = 1'b1;
      i_sample       = 16'hBEEF;
      repeat (3) @(posedge i_clk);
      #1;
      mon_en = 1'b1;
      cyc_step(1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
      check_reset_vals();

      // IDLE: valid held for 20 cycles, nothing accepted.
      repeat (20) cyc_step(1'b1, 16'($urandom), 1'b0, 2'd0, 1'b1);
      check_logs();

      // Reload bank 2; request level held into LOAD with a different bank, which is ignored.
      cyc_step(1'b0, 16'd0, 1'b1, 2'd2, 1'b1);
      repeat (3) cyc_step(1'($urandom_range(0, 1)), 16'($urandom), 1'b1, 2'd3, 1'b1);
      while (cyc < run_from) cyc_step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 2'd0, 1'b1);

      // RUN: 10 back-to-back samples, then a random valid pattern.
      repeat (10) cyc_step(1'b1, 16'($urandom), 1'b0, 2'd0, 1'b1);
      repeat (20) cyc_step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 2'd0, 1'b1);
      repeat (3) cyc_step(1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
      check_logs();

      // Sample accepted just before a reload, then valid alongside the request to bank 1.
      cyc_step(1'b1, 16'($urandom), 1'b0, 2'd0, 1'b1);
      cyc_step(1'b1, 16'($urandom), 1'b1, 2'd1, 1'b1);
      while (cyc < run_from) cyc_step(1'b1, 16'($urandom), 1'b0, 2'd0, 1'b1);
      repeat (5) cyc_step(1'b1, 16'($urandom), 1'b0, 2'd0, 1'b1);
      repeat (3) cyc_step(1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
      check_logs();

      // Reset during LOAD at idx 7 abandons the reload.
      cyc_step(1'b0, 16'd0, 1'b1, 2'd3, 1'b1);
      repeat (7) cyc_step(1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
      cyc_step(1'b0, 16'd0, 1'b0, 2'd0, 1'b0);
      cyc_step(1'b1, 16'($urandom), 1'b0, 2'd0, 1'b1);
      check_reset_vals();
      repeat (10) cyc_step(1'b1, 16'($urandom), 1'b0, 2'd0, 1'b1);
      check_logs();

      // A fresh reload to a random bank recovers normal operation.
      r = $urandom_range(0, NBANKS - 1);
      cyc_step(1'b1, 16'($urandom), 1'b1, 2'(r), 1'b1);
      while (cyc < run_from) cyc_step(1'b1, 16'($urandom), 1'b0, 2'd0, 1'b1);
      repeat (12) cyc_step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 2'd0, 1'b1);
      repeat (3) cyc_step(1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
      check_logs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
